// File: rtl/kronecker_pipe.sv
// Masked zero-test: first-order DOM AND tree over the negated XOR of two Boolean
// shares, one register level per tree level. KRONECKER_RAND_REUSE_EN shares rand bits across tree halves.
module kronecker_pipe #(
  parameter int WIDTH = 8,
  localparam int LEVELS = $clog2(WIDTH),
`ifdef KRONECKER_RAND_REUSE_EN
  localparam int RW = WIDTH / 2
`else
  localparam int RW = WIDTH - 1
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] inp,
  // "rand" is a reserved word in SystemVerilog, so the randomness port carries a suffix
  input  logic [RW-1:0]      rand_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [1:0]         Z
);

  localparam int NG = WIDTH - 1;

  // Map a gate number to the rand bit it consumes.
  function automatic int rand_idx(input int g);
`ifdef KRONECKER_RAND_REUSE_EN
    return (g < WIDTH / 2) ? g : (WIDTH - 2 - g);
`else
    return g;
`endif
  endfunction

  logic [NG-1:0]     a1_s, a0_s, b1_s, b0_s, r_s;
  logic [NG-1:0]     p11_q, p10_q, p00_q, p01_q;
  logic [NG-1:0]     z1_s, z0_s;
  logic [LEVELS-1:0] valid_q;

  // Each output share is an XOR of registers from its own share domain only.
  assign z1_s      = p11_q ^ p10_q;
  assign z0_s      = p00_q ^ p01_q;
  assign out_valid = valid_q[LEVELS-1];
  assign in_ready  = ~out_valid | out_ready;
  assign Z         = {z1_s[NG-1], z0_s[NG-1]};

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int OFF = WIDTH - (WIDTH >> (l - 1));
    localparam int N   = WIDTH >> l;
    for (genvar j = 0; j < N; j++) begin : g_gate
      localparam int G    = OFF + j;
      localparam int RIDX = rand_idx(G);
      if (l == 1) begin : g_leaf
        assign a1_s[G] = inp[2*j];
        assign a0_s[G] = ~inp[WIDTH+2*j];
        assign b1_s[G] = inp[2*j+1];
        assign b0_s[G] = ~inp[WIDTH+2*j+1];
        assign r_s[G]  = rand_i[RIDX];
      end else begin : g_inner
        localparam int P = OFF - (WIDTH >> (l - 1)) + 2 * j;
        logic [l-2:0] dly_q;
        assign a1_s[G] = z1_s[P];
        assign a0_s[G] = z0_s[P];
        assign b1_s[G] = z1_s[P+1];
        assign b0_s[G] = z0_s[P+1];
        assign r_s[G]  = dly_q[l-2];
        // Carry this gate's rand bit alongside its operand down the tree.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dly_q <= '0;
          end else if (in_ready) begin
            dly_q[0] <= rand_i[RIDX];
            for (int k = 1; k < l - 1; k++) begin
              dly_q[k] <= dly_q[k-1];
            end
          end
        end
      end
    end
  end

  // All four cross products are registered before any share recombination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p11_q <= '0;
      p10_q <= '0;
      p00_q <= '0;
      p01_q <= '0;
    end else if (in_ready) begin
      p11_q <= a1_s & b1_s;
      p10_q <= (a1_s & b0_s) ^ r_s;
      p00_q <= a0_s & b0_s;
      p01_q <= (a0_s & b1_s) ^ r_s;
    end
  end

  // Per-level valid bits shift with the data under the global stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (in_ready) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < LEVELS; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_kronecker_pipe.sv
// Scoreboard bench for kronecker_pipe (WIDTH=8): the reference answer for each
// accepted operand is simply (share0 ^ share1) == 0.
module tb_kronecker_pipe;
  localparam int WIDTH = 8;
`ifdef KRONECKER_RAND_REUSE_EN
  localparam int RW = WIDTH / 2;
`else
  localparam int RW = WIDTH - 1;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2*WIDTH-1:0] inp;
  logic [RW-1:0]      rand_i;
  logic               in_valid, in_ready, out_ready, out_valid;
  logic [1:0]         Z;

  int   checks   = 0;
  int   failures = 0;
  int   out_cnt  = 0;
  logic exp_q[$];

  kronecker_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .rand_i(rand_i), .in_valid(in_valid),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every result handed to the consumer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        chk("result", {31'd0, Z[1] ^ Z[0]}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  // One clock of stimulus; called just after a rising edge, returns #1 after the next.
  task automatic step(input logic v, input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1);
    logic acc;
    in_valid = v;
    inp      = {s1, s0};
    rand_i   = RW'($urandom());
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back((s0 ^ s1) == '0);
    #1;
  endtask

  task automatic rnd_op(output logic [WIDTH-1:0] s0, output logic [WIDTH-1:0] s1);
    int sel;
    s0  = WIDTH'($urandom());
    sel = $urandom_range(3, 0);
    case (sel)
      0, 1:    s1 = s0;
      2:       s1 = s0 ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
      default: s1 = WIDTH'($urandom());
    endcase
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    logic [1:0]       z_hold;
    int               base;

    rst_n = 1'b0; inp = '0; rand_i = '0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_Z", {30'd0, Z}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step(1'b0, '0, '0);

    // Equal shares, then exact three-cycle latency.
    step(1'b1, 8'h5A, 8'h5A);
    chk("lat_e0", {31'd0, out_valid}, 32'd0);
    step(1'b0, '0, '0);
    chk("lat_e1", {31'd0, out_valid}, 32'd0);
    step(1'b0, '0, '0);
    chk("lat_e2", {31'd0, out_valid}, 32'd1);
    chk("lat_Zxor", {31'd0, Z[1] ^ Z[0]}, 32'd1);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);

    // Single-bit differences at both ends, back to back.
    base = out_cnt;
    step(1'b1, 8'h00, 8'h01);
    step(1'b1, 8'h00, 8'h80);
    step(1'b0, '0, '0);
    chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, '0, '0);
    chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, '0, '0);
    chk("b2b_count", out_cnt - base, 32'd2);

    // 16-operand stream at full throughput.
    base = out_cnt;
    for (int i = 0; i < 16; i++) begin
      rnd_op(a, b);
      step(1'b1, a, b);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0);
    chk("stream_count", out_cnt - base, 32'd16);

    // Fill the pipe, then stall the consumer for five cycles.
    base = out_cnt;
    step(1'b1, 8'h33, 8'h33);
    step(1'b1, 8'h33, 8'h32);
    step(1'b1, 8'hC0, 8'hC0);
    out_ready = 1'b0;
    #1;
    z_hold = Z;
    chk("stall_full", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h11, 8'h22);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_Z", {30'd0, Z}, {30'd0, z_hold});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0);
    chk("stall_count", out_cnt - base, 32'd3);

    // Reset with two operands in flight.
    step(1'b1, 8'h77, 8'h77);
    step(1'b1, 8'h01, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("midrst_Z", {30'd0, Z}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0);
      chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Randomized valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(3, 0) != 0);
      rnd_op(a, b);
      step($urandom_range(1, 0) == 1, a, b);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, '0, '0);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
